// File: rtl/sram_stream_loader_if.sv
// -----------------------------------------------------------------------------
// sram_stream_loader_if
//   Groups the byte-stream handshake and the async SRAM bus that the
//   sram_stream_loader sits between.
//
//   modport master : the loader. It drives the SRAM bus and s_ready.
//                    It samples s_valid/s_data and ram_rdata.
//   modport slave  : the environment. It is the byte source plus the SRAM
//                    chips and the bus mux.
//
//   Signals
//     s_valid/s_ready/s_data : byte stream; a byte transfers when both are high
//     ram_addr               : SRAM word address
//     ram_wdata/ram_data_oe  : write data and its tristate enable
//     ram_rdata              : data read back from the bus
//     ram_ce_n               : one chip select per bank, active-low
//     ram_oe_n/ram_we_n      : read / write strobes, active-low
//     ram_be_n               : byte enables, active-low
// -----------------------------------------------------------------------------
interface sram_stream_loader_if #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int NUM_BANKS = 2
);
   logic                   s_valid;
   logic                   s_ready;
   logic [7:0]             s_data;

   logic [ADDR_W-1:0]      ram_addr;
   logic [DATA_W-1:0]      ram_wdata;
   logic                   ram_data_oe;
   logic [DATA_W-1:0]      ram_rdata;
   logic [NUM_BANKS-1:0]   ram_ce_n;
   logic                   ram_oe_n;
   logic                   ram_we_n;
   logic [DATA_W/8-1:0]    ram_be_n;

   modport master (
      input  s_valid, s_data, ram_rdata,
      output s_ready, ram_addr, ram_wdata, ram_data_oe,
             ram_ce_n, ram_oe_n, ram_we_n, ram_be_n
   );

   modport slave (
      output s_valid, s_data, ram_rdata,
      input  s_ready, ram_addr, ram_wdata, ram_data_oe,
             ram_ce_n, ram_oe_n, ram_we_n, ram_be_n
   );
endinterface

// File: rtl/sram_stream_loader.sv
// -----------------------------------------------------------------------------
// sram_stream_loader
//   Preload engine. It packs an incoming byte stream into DATA_W-bit words and
//   writes them to one of NUM_BANKS async SRAMs. Each word can optionally be
//   read back and compared.
//
//   Ports
//     clk, rst      : clock; asynchronous reset, active-high
//     start         : one-cycle job request. It is honoured only in IDLE.
//     abort         : stops the job. A write strobe that has begun is never torn.
//     bank_sel      : target bank, latched at start
//     base_addr     : first word address, latched at start
//     word_count    : number of words to write, latched at start
//     rev_endian    : 0 puts the first byte in the MSB; 1 puts it in the LSB
//     verify_en     : read back and compare every word
//     busy          : high outside IDLE
//     done          : one-cycle pulse when a job finishes cleanly
//     error         : sticky until the next accepted start
//     err_addr      : address of the word that failed to verify,
//                     or base_addr when the bank is bad
//     words_written : words committed by the current job
//     bus           : byte stream and SRAM bus (master side)
//
//   All outputs are registered. Each output register is loaded from the
//   decode of the next state, so the outputs always match the current state.
// -----------------------------------------------------------------------------
module sram_stream_loader #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int NUM_BANKS = 2,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [BANK_W-1:0]   bank_sel,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     word_count,
   input  logic                rev_endian,
   input  logic                verify_en,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [ADDR_W:0]     words_written,
   sram_stream_loader_if.master bus
);

   localparam int BPW     = DATA_W / 8;
   localparam int BCNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int CYC_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_COLLECT,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_VERIFY,
      S_NEXT,
      S_DONE,
      S_ERR
   } state_t;

   state_t                 state_q, state_d;

   // Job configuration, latched at start
   logic [BANK_W-1:0]      bank_q, bank_d;
   logic [ADDR_W:0]        count_q, count_d;
   logic                   rev_q, rev_d;
   logic                   verify_q, verify_d;

   // Datapath and bookkeeping
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      word_q, word_d;
   logic [BCNT_W-1:0]      byte_q, byte_d;
   logic [CYC_W-1:0]       cyc_q, cyc_d;
   logic                   abort_pend_q, abort_pend_d;
   logic [ADDR_W:0]        words_q, words_d;
   logic                   err_q, err_d;
   logic [ADDR_W-1:0]      err_addr_q, err_addr_d;

   // Registered outputs
   logic                   s_ready_q, s_ready_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [NUM_BANKS-1:0]   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;
   logic [BPW-1:0]         be_n_q, be_n_d;
   logic                   data_oe_q, data_oe_d;

   logic                   access;
   logic [DATA_W-1:0]      byte_ext;
   logic [ADDR_W:0]        words_inc;

   assign byte_ext  = DATA_W'(bus.s_data);
   assign words_inc = words_q + (ADDR_W + 1)'(1);

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets its default first so no path can infer a latch.
      state_d      = state_q;
      bank_d       = bank_q;
      count_d      = count_q;
      rev_d        = rev_q;
      verify_d     = verify_q;
      addr_d       = addr_q;
      word_d       = word_q;
      byte_d       = byte_q;
      cyc_d        = cyc_q;
      abort_pend_d = abort_pend_q;
      words_d      = words_q;
      err_d        = err_q;
      err_addr_d   = err_addr_q;

      case (state_q)
         S_IDLE: begin
            abort_pend_d = 1'b0;
            byte_d       = '0;
            // abort wins over a simultaneous start
            if (start && !abort) begin
               bank_d   = bank_sel;
               count_d  = word_count;
               rev_d    = rev_endian;
               verify_d = verify_en;
               addr_d   = base_addr;
               words_d  = '0;
               err_d    = 1'b0;
               if (int'(bank_sel) >= NUM_BANKS) begin
                  err_d      = 1'b1;
                  err_addr_d = base_addr;
                  state_d    = S_ERR;
               end else if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end

         S_COLLECT: begin
            if (abort) begin
               // any partially assembled word is simply dropped
               byte_d  = '0;
               state_d = S_IDLE;
            end else if (bus.s_valid && s_ready_q) begin
               word_d = rev_q ? ((word_q >> 8) | (byte_ext << (DATA_W - 8)))
                              : ((word_q << 8) | byte_ext);
               if (byte_q == BCNT_W'(BPW - 1)) begin
                  byte_d  = '0;
                  cyc_d   = '0;
                  state_d = S_SETUP;
               end else begin
                  byte_d = byte_q + BCNT_W'(1);
               end
            end
         end

         S_SETUP: begin
            // we_n has not fallen yet, so bailing out here writes nothing
            if (abort) begin
               state_d = S_IDLE;
            end else if (cyc_q == CYC_W'(SETUP_CYC - 1)) begin
               cyc_d   = '0;
               state_d = S_WRITE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         S_WRITE: begin
            // the strobe always runs its full width; abort is only remembered
            if (abort) abort_pend_d = 1'b1;
            if (cyc_q == CYC_W'(PULSE_CYC - 1)) begin
               cyc_d   = '0;
               state_d = S_HOLD;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         S_HOLD: begin
            cyc_d = '0;
            if (abort || abort_pend_q) state_d = S_IDLE;
            else if (verify_q)         state_d = S_VERIFY;
            else                       state_d = S_NEXT;
         end

         S_VERIFY: begin
            if (abort) abort_pend_d = 1'b1;
            if (cyc_q == CYC_W'(PULSE_CYC - 1)) begin
               cyc_d = '0;
               if (abort || abort_pend_q) begin
                  state_d = S_IDLE;
               end else if (bus.ram_rdata != word_q) begin
                  err_d      = 1'b1;
                  err_addr_d = addr_q;
                  state_d    = S_ERR;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         S_NEXT: begin
            // the address wraps naturally at 2**ADDR_W
            addr_d  = addr_q + ADDR_W'(1);
            words_d = words_inc;
            if (abort)                     state_d = S_IDLE;
            else if (words_inc == count_q) state_d = S_DONE;
            else                           state_d = S_COLLECT;
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Output decode of the state being entered
      access    = (state_d == S_SETUP) || (state_d == S_WRITE) ||
                  (state_d == S_HOLD)  || (state_d == S_VERIFY);
      s_ready_d = (state_d == S_COLLECT);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      ce_n_d    = access ? ~(NUM_BANKS'(1) << bank_d) : '1;
      be_n_d    = access ? '0 : '1;
      we_n_d    = (state_d != S_WRITE);
      oe_n_d    = (state_d != S_VERIFY);
      // the data bus is released on the same edge that oe_n falls
      data_oe_d = (state_d == S_SETUP) || (state_d == S_WRITE) ||
                  (state_d == S_HOLD);
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked logic uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      if (rst) begin
         state_q      <= S_IDLE;
         bank_q       <= '0;
         count_q      <= '0;
         rev_q        <= 1'b0;
         verify_q     <= 1'b0;
         addr_q       <= '0;
         word_q       <= '0;
         byte_q       <= '0;
         cyc_q        <= '0;
         abort_pend_q <= 1'b0;
         words_q      <= '0;
         err_q        <= 1'b0;
         err_addr_q   <= '0;
         s_ready_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ce_n_q       <= '1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         be_n_q       <= '1;
         data_oe_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         count_q      <= count_d;
         rev_q        <= rev_d;
         verify_q     <= verify_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         byte_q       <= byte_d;
         cyc_q        <= cyc_d;
         abort_pend_q <= abort_pend_d;
         words_q      <= words_d;
         err_q        <= err_d;
         err_addr_q   <= err_addr_d;
         s_ready_q    <= s_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         be_n_q       <= be_n_d;
         data_oe_q    <= data_oe_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = err_q;
   assign err_addr        = err_addr_q;
   assign words_written   = words_q;

   assign bus.s_ready     = s_ready_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_wdata   = word_q;
   assign bus.ram_data_oe = data_oe_q;
   assign bus.ram_ce_n    = ce_n_q;
   assign bus.ram_oe_n    = oe_n_q;
   assign bus.ram_we_n    = we_n_q;
   assign bus.ram_be_n    = be_n_q;

endmodule

// File: tb/tb_sram_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_sram_stream_loader
//   Directed bench for sram_stream_loader with a scoreboard.
//   - Each job pushes the SRAM writes it should produce onto exp_q.
//   - A negedge monitor detects each completed we_n pulse. It pops exp_q and
//     compares bank, address, data and pulse width.
//   - The monitor also models the SRAM for readback. bit0 can be forced
//     stuck at 0 to make a verify fail.
//   - It counts protocol violations and done pulses.
//   Three banks are used. With two, the 1-bit bank_sel cannot select an
//   illegal bank.
// -----------------------------------------------------------------------------
module tb_sram_stream_loader;

   localparam int ADDR_W    = 20;
   localparam int DATA_W    = 32;
   localparam int NUM_BANKS = 3;
   localparam int SETUP_CYC = 1;
   localparam int PULSE_CYC = 2;
   localparam int BANK_W    = 2;

   typedef struct {
      int                bank;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic                clk;
   logic                rst;
   logic                start;
   logic                abort;
   logic [BANK_W-1:0]   bank_sel;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W:0]     word_count;
   logic                rev_endian;
   logic                verify_en;
   logic                busy;
   logic                done;
   logic                error;
   logic [ADDR_W-1:0]   err_addr;
   logic [ADDR_W:0]     words_written;

   sram_stream_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)) bus ();

   sram_stream_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS),
      .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .bank_sel(bank_sel), .base_addr(base_addr), .word_count(word_count),
      .rev_endian(rev_endian), .verify_en(verify_en),
      .busy(busy), .done(done), .error(error), .err_addr(err_addr),
      .words_written(words_written), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   wr_t               exp_q[$];
   logic [DATA_W-1:0] mem [int];
   int                cyc = 0;
   int                viol = 0;
   int                done_seen = 0;
   int                wr_period = 0;
   int                last_fall = 0;
   int                pulse = 0;
   int                wr_bank = 0;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              we_prev = 1'b1;
   logic              done_prev = 1'b0;
   logic              stuck_bit0 = 1'b0;
   logic [NUM_BANKS-1:0] ce_seen = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor, scoreboard and SRAM model
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      int cur_bank;
      int zeros;
      wr_t e;
      if (rst) begin
         we_prev   = 1'b1;
         done_prev = 1'b0;
         pulse     = 0;
         bus.ram_rdata = '0;
      end else begin
         cyc++;
         ce_seen |= ~bus.ram_ce_n;
         if (!bus.ram_we_n && !bus.ram_oe_n) viol++;
         if (!bus.ram_oe_n && bus.ram_data_oe) viol++;
         if (bus.s_ready && (bus.ram_ce_n != '1 || !busy)) viol++;
         if (done && done_prev) viol++;
         if (done) done_seen++;
         done_prev = done;

         cur_bank = -1;
         zeros    = 0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (!bus.ram_ce_n[b]) begin
               cur_bank = b;
               zeros++;
            end
         end

         if (!bus.ram_we_n) begin
            if (zeros != 1 || bus.ram_be_n != '0 || !bus.ram_data_oe) viol++;
            if (we_prev) begin
               wr_period = cyc - last_fall;
               last_fall = cyc;
               wr_bank   = cur_bank;
               wr_addr   = bus.ram_addr;
               wr_data   = bus.ram_wdata;
               pulse     = 1;
            end else begin
               pulse++;
            end
         end else if (!we_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("wr_bank", 64'(wr_bank), 64'(e.bank));
               check("wr_addr", 64'(wr_addr), 64'(e.addr));
               check("wr_data", 64'(wr_data), 64'(e.data));
               check("we_pulse_width", 64'(pulse), 64'(PULSE_CYC));
            end
            mem[wr_bank * (1 << ADDR_W) + int'(wr_addr)] =
               stuck_bit0 ? (wr_data & ~DATA_W'(1)) : wr_data;
         end
         we_prev = bus.ram_we_n;

         if (!bus.ram_oe_n && cur_bank >= 0) begin
            int key;
            key = cur_bank * (1 << ADDR_W) + int'(bus.ram_addr);
            bus.ram_rdata = mem.exists(key) ? mem[key] : '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. Each one starts and ends just after a negedge.
   // ---------------------------------------------------------------------------
   task automatic push_exp(input int bank, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
      wr_t w;
      w.bank = bank;
      w.addr = addr;
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic start_job(input logic [BANK_W-1:0] bank, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W:0] cnt, input logic rev, input logic ver);
      bank_sel   = bank;
      base_addr  = base;
      word_count = cnt;
      rev_endian = rev;
      verify_en  = ver;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   // Sends n bytes of v, most significant byte first, with gap idle cycles
   // between bytes.
   task automatic send_bytes(input logic [63:0] v, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         bus.s_valid = 1'b1;
         bus.s_data  = v[8*(n-1-i) +: 8];
         while (!bus.s_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (!bus.s_ready) begin
            check("stream_accept_timeout", 64'(bus.s_ready), 64'd1);
            bus.s_valid = 1'b0;
            return;
         end
         @(negedge clk);
         bus.s_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (busy && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check(name, 64'(busy), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      // order: busy done error s_ready data_oe we_n oe_n
      check({tag, "_ctrl"}, 64'({busy, done, error, bus.s_ready, bus.ram_data_oe,
                                 bus.ram_we_n, bus.ram_oe_n}), 64'b0000011);
      check({tag, "_ce_be"}, 64'({bus.ram_ce_n, bus.ram_be_n}), 64'h7F);
      check({tag, "_counters"}, 64'({words_written, err_addr}), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed tests
   // ---------------------------------------------------------------------------
   initial begin
      int d0;
      int k;
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      bank_sel    = '0;
      base_addr   = '0;
      word_count  = '0;
      rev_endian  = 1'b0;
      verify_en   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #4 rst = 1'b0;
      @(negedge clk);

      // 1: rev0, two words, no stall -> 9-cycle word period
      d0 = done_seen;
      push_exp(0, 20'h00010, 32'h0001_0203);
      push_exp(0, 20'h00011, 32'h0405_0607);
      start_job(2'd0, 20'h00010, 21'd2, 1'b0, 1'b0);
      send_bytes(64'h0001_0203_0405_0607, 8, 0);
      wait_idle("t1_idle");
      check("t1_done_pulses", 64'(done_seen - d0), 64'd1);
      check("t1_words_written", 64'(words_written), 64'd2);
      check("t1_word_period", 64'(wr_period), 64'd9);

      // 2: rev1, bank1 never selected
      ce_seen = '0;
      d0 = done_seen;
      push_exp(0, 20'h00010, 32'h0302_0100);
      push_exp(0, 20'h00011, 32'h0706_0504);
      start_job(2'd0, 20'h00010, 21'd2, 1'b1, 1'b0);
      send_bytes(64'h0001_0203_0405_0607, 8, 0);
      wait_idle("t2_idle");
      check("t2_done_pulses", 64'(done_seen - d0), 64'd1);
      check("t2_ce_other_banks", 64'(ce_seen), 64'b001);

      // verify that passes, bank1 -> 11-cycle word period
      d0 = done_seen;
      push_exp(1, 20'h00030, 32'hA55A_C33C);
      push_exp(1, 20'h00031, 32'h1234_5678);
      start_job(2'd1, 20'h00030, 21'd2, 1'b0, 1'b1);
      send_bytes(64'hA55A_C33C_1234_5678, 8, 0);
      wait_idle("tv_idle");
      check("tv_done_pulses", 64'(done_seen - d0), 64'd1);
      check("tv_error", 64'(error), 64'd0);
      check("tv_word_period", 64'(wr_period), 64'd11);

      // 3: verify against a stuck bit0 -> error at 0x00020
      stuck_bit0 = 1'b1;
      d0 = done_seen;
      push_exp(0, 20'h00020, 32'h0000_0001);
      start_job(2'd0, 20'h00020, 21'd1, 1'b0, 1'b1);
      send_bytes(64'h0000_0001, 4, 0);
      wait_idle("t3_idle");
      stuck_bit0 = 1'b0;
      check("t3_error", 64'(error), 64'd1);
      check("t3_err_addr", 64'(err_addr), 64'h00020);
      check("t3_done_pulses", 64'(done_seen - d0), 64'd0);
      check("t3_words_written", 64'(words_written), 64'd0);

      // 4: address wrap, stream gaps, start while busy is ignored
      d0 = done_seen;
      push_exp(1, 20'hFFFFF, 32'h1122_3344);
      push_exp(1, 20'h00000, 32'h5566_7788);
      start_job(2'd1, 20'hFFFFF, 21'd2, 1'b0, 1'b0);
      check("t4_error_cleared", 64'(error), 64'd0);
      send_bytes(64'h1122, 2, 2);
      start_job(2'd0, 20'h00123, 21'd7, 1'b1, 1'b1);
      send_bytes(64'h3344_5566_7788, 6, 2);
      wait_idle("t4_idle");
      check("t4_done_pulses", 64'(done_seen - d0), 64'd1);
      check("t4_words_written", 64'(words_written), 64'd2);

      // 5: zero count, bad bank, abort beats start
      ce_seen = '0;
      d0 = done_seen;
      start_job(2'd0, 20'h00055, 21'd0, 1'b0, 1'b0);
      check("t5_done_next_cycle", 64'(done), 64'd1);
      @(negedge clk);
      check("t5_done_one_cycle", 64'({done, busy}), 64'd0);
      check("t5_zero_done_pulses", 64'(done_seen - d0), 64'd1);
      d0 = done_seen;
      start_job(2'd3, 20'h0ABCD, 21'd5, 1'b0, 1'b0);
      check("t5_bad_bank_error", 64'(error), 64'd1);
      check("t5_bad_bank_err_addr", 64'(err_addr), 64'h0ABCD);
      wait_idle("t5_idle");
      check("t5_bad_bank_no_done", 64'(done_seen - d0), 64'd0);
      check("t5_no_ce_activity", 64'(ce_seen), 64'd0);
      abort = 1'b1;
      start_job(2'd0, 20'h00001, 21'd1, 1'b0, 1'b0);
      abort = 1'b0;
      check("t5_abort_beats_start", 64'({busy, error}), 64'b01);

      // 6a: abort in the first WRITE cycle
      d0 = done_seen;
      push_exp(0, 20'h00060, 32'hCAFE_F00D);
      start_job(2'd0, 20'h00060, 21'd3, 1'b0, 1'b0);
      send_bytes(64'hCAFE_F00D, 4, 0);
      k = 0;
      while (bus.ram_we_n && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t6_reach_write", 64'(bus.ram_we_n), 64'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      k = 1;
      while (busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("t6_idle_after_hold", 64'(k), 64'd3);
      check("t6_no_done", 64'(done_seen - d0), 64'd0);
      check("t6_words_written", 64'(words_written), 64'd0);
      check("t6_no_error", 64'(error), 64'd0);

      // 6b: reset in the middle of COLLECT
      start_job(2'd1, 20'h00070, 21'd2, 1'b0, 1'b0);
      send_bytes(64'hBEEF, 2, 0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("t6_mid_reset");
      #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      check("t6_idle_after_reset", 64'(busy), 64'd0);

      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
      check("protocol_violations", 64'(viol), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected the run to end before 400000");
      $fatal(1, "watchdog expired");
   end

endmodule
